shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//  Command sequencer sitting directly upstream of the universal shift register (shift_reg).
//  Accepts one command per valid/ready handshake: a parallel word, an operation and a shift count.
//  Drives the register's S/PI/SI inputs cycle by cycle: one parallel load, then N shifts.
//  Pulses done once the register holds the final result.
//  Rotate mode feeds the register's own output back as the serial input.
// PARAMETERS
//  SIZE   4  data width; must equal SIZE of the driven shift_reg (>= 2)
//  CNT_W  3  width of the shift-count field; max count = 2**CNT_W-1
// PORTS
//  clk        in   1      rising-edge clock, shared with shift_reg
//  rst        in   1      synchronous, active-high reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      sequencer can accept; high only in IDLE
//  cmd_op     in   2      00 load-only, 01 shift right, 10 shift left, 11 rotate right
//  cmd_data   in   SIZE   word to parallel-load
//  cmd_cnt    in   CNT_W  number of shift cycles (ignored for op 00)
//  cmd_fill   in   1      serial fill bit for ops 01/10
//  sr_out     in   SIZE   shift_reg.out, used as feedback for rotate
//  sr_S       out  2      to shift_reg.S (00 hold, 01 right, 10 left, 11 load)
//  sr_PI      out  SIZE   to shift_reg.PI
//  sr_SI      out  1      to shift_reg.SI
//  busy       out  1      high in every state except IDLE
//  done       out  1      one-cycle pulse: result is valid on sr_out
// BEHAVIOUR
//  Reset value of every output: cmd_ready=1, sr_S=00, sr_PI=0, sr_SI=0, busy=0, done=0.
//  Reset empties the command latch and clears the count.
//  FSM states IDLE, LOAD, SHIFT, DONE. All outputs are decoded from the registered state
//  and latches (Moore); there are no combinational paths from cmd_* to outputs.
//  IDLE:  sr_S=00. The command is accepted on an edge where cmd_valid && cmd_ready.
//         On accept, latch op/data/cnt/fill and go to LOAD.
//  LOAD:  one cycle. sr_S=11, sr_PI=latched data. Next state:
//         SHIFT if op!=00 and cnt!=0; otherwise DONE.
//  SHIFT: exactly cnt cycles. sr_S=01 for ops 01/11, sr_S=10 for op 10.
//         sr_SI = fill for ops 01/10; sr_SI = sr_out[0] for op 11.
//         Internal down-counter is loaded with cnt in LOAD and decremented each SHIFT cycle.
//         Exit to DONE when the counter reaches 1 and that final shift cycle has completed.
//  DONE:  one cycle. sr_S=00, done=1, then IDLE.
//  Timing: accept at edge E0 -> register loaded at E1 -> shifts at E2..E(cnt+1).
//    busy and cmd_ready=0 for cnt+2 cycles (2 cycles for op 00 or cnt=0).
//    done is high in the cycle after the last register update.
//  Back-pressure: cmd_valid held high while busy is ignored (cmd_ready=0).
//    The earliest next accept is the edge ending the first IDLE cycle after DONE.
//  sr_PI = latched data in all states; only LOAD makes it take effect.
//  sr_SI = 0 outside SHIFT.
//  cnt > SIZE is legal: excess shifts keep filling (ops 01/10) or keep rotating (op 11).
//  Rotate for cnt = SIZE returns the original word.
//  rst asserted mid-operation: next cycle is IDLE with reset outputs.
//    No done pulse is produced for the aborted command.
//  cmd_* inputs change while busy: no effect; the latched values are used.
// TESTING (SIZE=4, CNT_W=3, shift_reg instantiated as DUT load)
//  1 op01 data=1011 cnt=2 fill=0 -> sr_out=0010 when done; busy 4 cycles; done 1 cycle
//  2 op10 data=1011 cnt=1 fill=1 -> sr_out=0111; op10 data=1011 cnt=7 fill=0 -> 0000
//  3 op11 data=1011 cnt=1 -> 1101; op11 data=1011 cnt=4 -> 1011
//  4 op00 data=0110 cnt=5, and op01 data=0110 cnt=0 -> sr_out=0110, done 2 cycles after accept
//  5 cmd_valid held high with new data during busy -> only one accept; cmd_ready=0 until
//    after done; the second command is accepted from IDLE and its result is checked
//  6 rst pulsed during SHIFT of op01 cnt=5 -> next cycle IDLE, sr_S=00, busy=0,
//    no done pulse; a following command completes correctly

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a universal shift register: one parallel load followed by
// N shift/rotate cycles per accepted command, then a one-cycle done pulse.
module shift_seq_ctrl #(
  parameter int SIZE  = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [SIZE-1:0]  cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             cmd_fill,
  input  logic [SIZE-1:0]  sr_out,
  output logic [1:0]       sr_S,
  output logic [SIZE-1:0]  sr_PI,
  output logic             sr_SI,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_ROR  = 2'b11
  } op_e;

  localparam logic [1:0] S_HOLD  = 2'b00;
  localparam logic [1:0] S_RIGHT = 2'b01;
  localparam logic [1:0] S_LEFT  = 2'b10;
  localparam logic [1:0] S_LOAD  = 2'b11;

  state_e           state, state_nxt;
  op_e              op_q;
  logic [SIZE-1:0]  data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] ctr_q;
  logic             fill_q;
  logic             accept;

  assign accept = (state == IDLE) && cmd_valid;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_LOAD;
      data_q <= '0;
      cnt_q  <= '0;
      ctr_q  <= '0;
      fill_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= op_e'(cmd_op);
        data_q <= cmd_data;
        cnt_q  <= cmd_cnt;
        fill_q <= cmd_fill;
      end
      if (state == LOAD) begin
        ctr_q <= cnt_q;
      end else if (state == SHIFT) begin
        ctr_q <= ctr_q - CNT_W'(1);
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = LOAD;
      LOAD:    state_nxt = (op_q != OP_LOAD && cnt_q != '0) ? SHIFT : DONE;
      SHIFT:   if (ctr_q == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs: decoded only from state and latched command, never from cmd_*.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    sr_S      = S_HOLD;
    sr_SI     = 1'b0;
    sr_PI     = data_q;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      LOAD: sr_S = S_LOAD;
      SHIFT: begin
        sr_S  = (op_q == OP_SHL) ? S_LEFT : S_RIGHT;
        sr_SI = (op_q == OP_ROR) ? sr_out[0] : fill_q;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Only bit 0 of the register output is needed for rotate feedback.
  logic unused_sr_out;
  assign unused_sr_out = ^sr_out[SIZE-1:1];

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl driving a behavioural 4-bit universal shift register.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_cnt;
  logic       cmd_fill;
  logic [3:0] sr_out;
  logic [1:0] sr_S;
  logic [3:0] sr_PI;
  logic       sr_SI;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] res;
    int         busy_len;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  shift_seq_ctrl #(.SIZE(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_cnt   (cmd_cnt),
    .cmd_fill  (cmd_fill),
    .sr_out    (sr_out),
    .sr_S      (sr_S),
    .sr_PI     (sr_PI),
    .sr_SI     (sr_SI),
    .busy      (busy),
    .done      (done)
  );

  // Load model: universal shift register (00 hold, 01 right, 10 left, 11 load).
  always_ff @(posedge clk) begin
    case (sr_S)
      2'b01:   sr_out <= {sr_SI, sr_out[3:1]};
      2'b10:   sr_out <= {sr_out[2:0], sr_SI};
      2'b11:   sr_out <= sr_PI;
      default: sr_out <= sr_out;
    endcase
  end

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int busy_len(input logic [1:0] op, input logic [2:0] cnt);
    return (op == 2'b00 || cnt == 3'd0) ? 2 : int'(cnt) + 2;
  endfunction

  // Monitor: checks cmd_ready/busy exclusivity, done width, and pops the scoreboard on done.
  int  busy_run  = 0;
  bit  prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      check(cmd_ready == !busy, "ready_vs_busy", int'(cmd_ready), int'(!busy));
      if (busy) busy_run++;
      else      busy_run = 0;
      if (done) begin
        check(!prev_done, "done_width", 2, 1);
        check(sb.size() != 0, "unexpected_done", int'(sr_out), 0);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check(sr_out == e.res, "result", int'(sr_out), int'(e.res));
          check(busy_run == e.busy_len, "busy_cycles", busy_run, e.busy_len);
        end
      end
      prev_done = done;
    end else begin
      busy_run  = 0;
      prev_done = 1'b0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(cmd_ready == 1'b1, "ready_timeout", int'(cmd_ready), 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(sb.size() == 0, "done_timeout", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] data,
                       input logic [2:0] cnt, input logic fill);
    cmd_op    = op;
    cmd_data  = data;
    cmd_cnt   = cnt;
    cmd_fill  = fill;
    cmd_valid = 1'b1;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt,
                      input logic fill, input logic [3:0] res);
    exp_t e;
    wait_ready();
    drive(op, data, cnt, fill);
    e.res      = res;
    e.busy_len = busy_len(op, cnt);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    exp_t e;
    int   n;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'h0;
    cmd_cnt   = 3'd0;
    cmd_fill  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check(cmd_ready == 1'b1, "rst_cmd_ready", int'(cmd_ready), 1);
    check(sr_S == 2'b00,     "rst_sr_S",      int'(sr_S), 0);
    check(sr_PI == 4'h0,     "rst_sr_PI",     int'(sr_PI), 0);
    check(sr_SI == 1'b0,     "rst_sr_SI",     int'(sr_SI), 0);
    check(busy == 1'b0,      "rst_busy",      int'(busy), 0);
    check(done == 1'b0,      "rst_done",      int'(done), 0);

    // Shift right, shift left (incl. count beyond width), rotate (incl. full and over-turn)
    send(2'b01, 4'b1011, 3'd2, 1'b0, 4'b0010);
    send(2'b10, 4'b1011, 3'd1, 1'b1, 4'b0111);
    send(2'b10, 4'b1011, 3'd7, 1'b0, 4'b0000);
    send(2'b11, 4'b1011, 3'd1, 1'b0, 4'b1101);
    send(2'b11, 4'b1011, 3'd4, 1'b0, 4'b1011);
    send(2'b11, 4'b1011, 3'd6, 1'b1, 4'b1110);
    send(2'b01, 4'b1011, 3'd7, 1'b1, 4'b1111);
    // Load-only and zero count both finish two cycles after accept
    send(2'b00, 4'b0110, 3'd5, 1'b1, 4'b0110);
    send(2'b01, 4'b0110, 3'd0, 1'b1, 4'b0110);

    // cmd_valid held through busy with changed fields: A then B, one accept each
    wait_ready();
    drive(2'b01, 4'b1011, 3'd3, 1'b1);
    e.res = 4'b1111; e.busy_len = 5; sb.push_back(e);
    e.res = 4'b0100; e.busy_len = 4; sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    drive(2'b10, 4'b0001, 3'd2, 1'b0);
    n = 0;
    while (!cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(cmd_ready == 1'b1, "held_valid_ready", int'(cmd_ready), 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_drain();

    // Reset during SHIFT aborts with no done pulse
    wait_ready();
    drive(2'b01, 4'b1111, 3'd5, 1'b0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check(sr_S == 2'b01, "pre_abort_shift", int'(sr_S), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check(sr_S == 2'b00,     "abort_sr_S",      int'(sr_S), 0);
    check(busy == 1'b0,      "abort_busy",      int'(busy), 0);
    check(cmd_ready == 1'b1, "abort_cmd_ready", int'(cmd_ready), 1);
    check(done == 1'b0,      "abort_done",      int'(done), 0);
    repeat (10) @(negedge clk);
    send(2'b11, 4'b0110, 3'd2, 1'b0, 4'b1001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
